ipa_exec_ctrl: RTL and testbench
================================

Name: ipa_exec_ctrl

Overview:
- Execution sequencer for the IPA array. Sits directly downstream of the IPA configuration register block and consumes its COMMAND writes.
- On a start command it fetches N configuration words from memory over a req/gnt/rvalid port and streams them into the array. It then starts the array, waits for array completion, and returns a one-cycle ipa_exec_complete pulse. The register block uses that pulse to set STATUS.

Parameters:
- DATA_WIDTH, 32, width of command word, memory data and array config data
- ADDR_WIDTH, 32, memory address width
- MAX_OUT, 4, maximum outstanding memory reads (power of 2, ≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  one-cycle pulse: COMMAND register written
- cmd_word  in  DATA_WIDTH  command: [0] start, [15:8] cfg word count N, other bits reserved/ignored
- cfg_base_addr  in  ADDR_WIDTH  byte address of first config word
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_WIDTH  read address, word-aligned
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read data
- arr_cfg_valid  out  1  config word valid to array (array never stalls)
- arr_cfg_data  out  DATA_WIDTH  config word
- arr_start  out  1  one-cycle array start pulse
- arr_done  in  1  array finished (pulse or level)
- busy  out  1  high in any state except IDLE
- cmd_rejected  out  1  one-cycle pulse: start command arrived while busy
- ipa_exec_complete  out  1  one-cycle completion pulse

Behaviour:
- Reset: FSM → IDLE. All counters 0. All outputs 0.
- Reset mid-operation aborts immediately. Responses for in-flight reads are the memory side's concern.
- FSM states: IDLE, FETCH, EXEC, DONE.
- IDLE, on cmd_valid & cmd_word[0]:
  - Latch N and cfg_base_addr.
  - Clear issue_cnt, recv_cnt, outstanding.
  - N≠0 → FETCH.
  - N=0 → EXEC, with arr_start asserted the following cycle.
- cmd_valid with start=0 is ignored in every state.
- FETCH, issue side:
  - mem_req=1 while issue_cnt<N and outstanding<MAX_OUT.
  - mem_addr = base + 4*issue_cnt (mod 2^ADDR_WIDTH, wraps silently).
  - mem_req/mem_addr are combinational from registered state.
  - A request is held until mem_gnt. On req&gnt, issue_cnt increments.
- FETCH, response side:
  - On mem_rvalid, arr_cfg_valid=1 and arr_cfg_data=mem_rdata, registered: 1-cycle latency from rvalid. recv_cnt increments.
  - Responses return in order. rvalid never precedes its gnt.
- Outstanding count: +1 on gnt, -1 on rvalid. A same-cycle gnt and rvalid leave it unchanged.
- FETCH → EXEC when recv_cnt reaches N. arr_start pulses for exactly 1 cycle on entry to EXEC. The last arr_cfg_valid and arr_start occur in the same cycle.
- EXEC: wait for arr_done=1 (sampled from the cycle after arr_start) → DONE. arr_done before arr_start is ignored.
- DONE: ipa_exec_complete=1 for exactly 1 cycle, then → IDLE. busy falls in the same cycle the FSM enters IDLE.
- Start command while busy (FETCH/EXEC/DONE):
  - Command is dropped; the current operation is unaffected.
  - cmd_rejected pulses 1 cycle later.
- Spurious mem_rvalid outside FETCH: ignored, no arr_cfg_valid.
- Counter widths: 8 bits for N/issue/recv. Outstanding counter is $clog2(MAX_OUT)+1 bits.

Decomposition:
- Package ipa_exec_pkg:
  - state enum (IDLE, FETCH, EXEC, DONE)
  - command field constants: CMD_START_BIT=0, CMD_CNT_LSB=8, CMD_CNT_MSB=15
  - word stride constant WORD_BYTES=4
- Sub-module ipa_rd_fetcher: the issue/outstanding/receive counters and memory handshake. It takes start, N and base, and returns a done flag plus the data stream.
- The FSM, start pulse and completion pulse stay in ipa_exec_ctrl.

Test Plan:
- Basic run:
  - Stimulus: base=0x1000, cmd_word=0x0301, mem_gnt always 1, rvalid 2 cycles after gnt, arr_done 5 cycles after arr_start.
  - Response: addresses 0x1000, 0x1004, 0x1008; 3 arr_cfg_valid beats carrying the data; arr_start once; ipa_exec_complete one cycle after arr_done; busy low afterward.
- N=0: cmd_word=0x0001 → no mem_req; arr_start the cycle after the command; completion after arr_done.
- Backpressure and throttling:
  - Stimulus: N=8, MAX_OUT=4, mem_gnt low for 3 cycles, then high; rvalid delayed 10 cycles.
  - Response: mem_req/mem_addr held stable while gnt is low; never more than 4 outstanding; 8 data beats in order.
- Reject while busy: second start command during EXEC → cmd_rejected pulse 1 cycle later; exactly one completion; second command has no effect.
- Reset mid-FETCH: rst_n low after 2 of 5 words received → outputs 0 immediately; a new command after reset runs cleanly from word 0.
- Address wrap: base=0xFFFF_FFFC, N=2 → addresses 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/ipa_exec_pkg.sv
// rtl/ipa_exec_pkg.sv - shared state encoding and command field layout for the IPA execution sequencer
package ipa_exec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } exec_state_t;

    localparam int CMD_START_BIT = 0;
    localparam int CMD_CNT_LSB   = 8;
    localparam int CMD_CNT_MSB   = 15;
    localparam int CNT_WIDTH     = CMD_CNT_MSB - CMD_CNT_LSB + 1;
    localparam int WORD_BYTES    = 4;

endpackage

// File: rtl/ipa_rd_fetcher.sv
// rtl/ipa_rd_fetcher.sv - issues N word reads with bounded outstanding count and streams responses out
module ipa_rd_fetcher
    import ipa_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  active,
    input  logic [CNT_WIDTH-1:0]  word_cnt,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cfg_tvalid,
    output logic [DATA_WIDTH-1:0] cfg_tdata,
    output logic                  fetch_done
);

    localparam int OUT_W = $clog2(MAX_OUT) + 1;

    logic [CNT_WIDTH-1:0]  n_q;
    logic [CNT_WIDTH-1:0]  issue_cnt;
    logic [CNT_WIDTH-1:0]  recv_cnt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [OUT_W-1:0]      outstanding;
    logic                  issue;
    logic                  accept;

    assign mem_req  = active && (issue_cnt < n_q) && (outstanding < OUT_W'(MAX_OUT));
    assign mem_addr = mem_req ? base_q + ADDR_WIDTH'(issue_cnt) * ADDR_WIDTH'(WORD_BYTES) : '0;

    assign issue  = mem_req && mem_gnt;
    // Responses outside an active fetch are stray and must not reach the array.
    assign accept = active && mem_rvalid;

    // Fires on the last response so the sequencer can start the array alongside the final beat.
    assign fetch_done = accept && (recv_cnt == n_q - CNT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q         <= '0;
            base_q      <= '0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            outstanding <= '0;
            cfg_tvalid  <= 1'b0;
            cfg_tdata   <= '0;
        end else begin
            cfg_tvalid <= accept;
            if (accept) begin
                cfg_tdata <= mem_rdata;
            end
            if (start) begin
                n_q         <= word_cnt;
                base_q      <= base_addr;
                issue_cnt   <= '0;
                recv_cnt    <= '0;
                outstanding <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + CNT_WIDTH'(1);
                end
                if (accept) begin
                    recv_cnt <= recv_cnt + CNT_WIDTH'(1);
                end
                case ({issue, accept})
                    2'b10:   outstanding <= outstanding + OUT_W'(1);
                    2'b01:   outstanding <= outstanding - OUT_W'(1);
                    default: outstanding <= outstanding;
                endcase
            end
        end
    end

endmodule

// File: rtl/ipa_exec_ctrl.sv
// rtl/ipa_exec_ctrl.sv - IPA execution sequencer: fetch config words, start array, report completion
module ipa_exec_ctrl
    import ipa_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic [DATA_WIDTH-1:0] cmd_word,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  arr_cfg_valid,
    output logic [DATA_WIDTH-1:0] arr_cfg_data,
    output logic                  arr_start,
    input  logic                  arr_done,
    output logic                  busy,
    output logic                  cmd_rejected,
    output logic                  ipa_exec_complete
);

    exec_state_t          state;
    exec_state_t          state_nxt;
    logic                 start_cmd;
    logic                 launch;
    logic                 fetch_done;
    logic                 arr_start_q;
    logic                 rejected_q;
    logic [CNT_WIDTH-1:0] cmd_cnt;
    logic                 unused_cmd_bits;

    assign start_cmd       = cmd_valid && cmd_word[CMD_START_BIT];
    assign cmd_cnt         = cmd_word[CMD_CNT_MSB:CMD_CNT_LSB];
    assign launch          = (state == ST_IDLE) && start_cmd;
    assign unused_cmd_bits = ^{cmd_word[DATA_WIDTH-1:CMD_CNT_MSB+1], cmd_word[CMD_CNT_LSB-1:CMD_START_BIT+1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            arr_start_q <= 1'b0;
            rejected_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            arr_start_q <= (state_nxt == ST_EXEC) && (state != ST_EXEC);
            rejected_q  <= start_cmd && (state != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt         = state;
        busy              = (state != ST_IDLE);
        ipa_exec_complete = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_cmd) begin
                    state_nxt = (cmd_cnt == '0) ? ST_EXEC : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetch_done) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // A done seen in the start cycle belongs to a previous run, not this one.
                if (arr_done && !arr_start_q) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ipa_exec_complete = 1'b1;
                state_nxt         = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign arr_start    = arr_start_q;
    assign cmd_rejected = rejected_q;

    ipa_rd_fetcher #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_OUT    (MAX_OUT)
    ) u_fetcher (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (launch),
        .active     (state == ST_FETCH),
        .word_cnt   (cmd_cnt),
        .base_addr  (cfg_base_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .cfg_tvalid (arr_cfg_valid),
        .cfg_tdata  (arr_cfg_data),
        .fetch_done (fetch_done)
    );

endmodule

// File: tb/tb_ipa_exec_ctrl.sv
// tb/tb_ipa_exec_ctrl.sv - randomized self-checking bench for ipa_exec_ctrl against a cycle-event model
module tb_ipa_exec_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic [DW-1:0] cmd_word;
    logic [AW-1:0] cfg_base_addr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          arr_cfg_valid;
    logic [DW-1:0] arr_cfg_data;
    logic          arr_start;
    logic          arr_done;
    logic          busy;
    logic          cmd_rejected;
    logic          ipa_exec_complete;

    always #5 clk = ~clk;

    ipa_exec_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUT(MO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_word          (cmd_word),
        .cfg_base_addr     (cfg_base_addr),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_gnt           (mem_gnt),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .arr_cfg_valid     (arr_cfg_valid),
        .arr_cfg_data      (arr_cfg_data),
        .arr_start         (arr_start),
        .arr_done          (arr_done),
        .busy              (busy),
        .cmd_rejected      (cmd_rejected),
        .ipa_exec_complete (ipa_exec_complete)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model of one operation, tracked as expected event cycles rather than FSM states.
    bit          op = 1'b0;
    bit          start_pending = 1'b0;
    int          cmd_cyc, n_m, issued, rcv, last_due;
    logic [31:0] base_m;
    int          exp_start = -1;
    int          exp_cmp   = -1;
    int          exp_rej   = -1;
    int          beat_cyc  = -1;
    logic [31:0] beat_data;
    int          due_q[$];
    logic [31:0] addr_q[$];
    int          gnt_pct, lat_min, lat_max, done_dly;
    bit          noise, rej_exec;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mdata(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    task automatic check_zero(string tag);
        check({tag, "_mem_req"},  32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_cfg_v"},    32'(arr_cfg_valid), 32'd0);
        check({tag, "_cfg_d"},    arr_cfg_data, 32'd0);
        check({tag, "_start"},    32'(arr_start), 32'd0);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_rej"},      32'(cmd_rejected), 32'd0);
        check({tag, "_cmpl"},     32'(ipa_exec_complete), 32'd0);
    endtask

    task automatic tick();
        bit fetch, exp_req, in_busy, rej;
        int lat;
        @(negedge clk);
        cyc++;
        fetch   = op && (cyc > cmd_cyc) && (n_m != 0) && (rcv < n_m);
        exp_req = fetch && (issued < n_m) && ((issued - rcv) < MO);
        in_busy = op && (cyc > cmd_cyc) && (exp_cmp < 0 || cyc <= exp_cmp);
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (mem_req && exp_req) check("mem_addr", mem_addr, base_m + 32'(4 * issued));
        check("arr_start", 32'(arr_start), 32'(cyc == exp_start));
        check("complete", 32'(ipa_exec_complete), 32'(cyc == exp_cmp));
        check("busy", 32'(busy), 32'(in_busy));
        check("cmd_rejected", 32'(cmd_rejected), 32'(cyc == exp_rej));
        check("cfg_valid", 32'(arr_cfg_valid), 32'(cyc == beat_cyc));
        if (cyc == beat_cyc) check("cfg_data", arr_cfg_data, beat_data);

        cmd_valid     = 1'b0;
        cmd_word      = $urandom;
        cmd_word[0]   = 1'b0;
        cfg_base_addr = $urandom;
        mem_rvalid    = 1'b0;
        mem_rdata     = $urandom;
        arr_done      = 1'b0;
        if (start_pending) begin
            cmd_valid        = 1'b1;
            cmd_word[0]      = 1'b1;
            cmd_word[15:8]   = 8'(n_m);
            cfg_base_addr    = base_m;
            op               = 1'b1;
            start_pending    = 1'b0;
            cmd_cyc          = cyc;
            issued           = 0;
            rcv              = 0;
            exp_cmp          = -1;
            exp_start        = (n_m == 0) ? cyc + 1 : -1;
            last_due         = cyc;
        end else begin
            rej = in_busy && ((rej_exec && exp_start >= 0 && cyc == exp_start + 1) ||
                              (noise && $urandom_range(15) == 0));
            if (rej) begin
                cmd_valid   = 1'b1;
                cmd_word[0] = 1'b1;
                exp_rej     = cyc + 1;
            end else if (noise && $urandom_range(7) == 0) begin
                cmd_valid = 1'b1;
            end
        end

        mem_gnt = ($urandom_range(99) < gnt_pct);
        if (mem_req && mem_gnt) begin
            lat      = $urandom_range(lat_max, lat_min);
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            due_q.push_back(last_due);
            addr_q.push_back(mem_addr);
            issued++;
        end
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            mem_rvalid = 1'b1;
            mem_rdata  = mdata(addr_q.pop_front());
            beat_cyc   = cyc + 1;
            beat_data  = mdata(base_m + 32'(4 * rcv));
            rcv++;
            if (rcv == n_m) exp_start = cyc + 1;
        end else if (noise && !fetch && $urandom_range(5) == 0) begin
            mem_rvalid = 1'b1;
        end

        if (op && exp_start >= 0 && exp_cmp < 0 && cyc == exp_start + done_dly) begin
            arr_done = 1'b1;
            exp_cmp  = cyc + 1;
        end else if (noise && (!op || exp_start < 0 || cyc <= exp_start || exp_cmp >= 0)) begin
            arr_done = ($urandom_range(3) == 0);
        end

        if (op && exp_cmp >= 0 && cyc == exp_cmp + 1) op = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        arr_done   = 1'b0;
        #1;
        check_zero("async_rst");
        op            = 1'b0;
        start_pending = 1'b0;
        due_q.delete();
        addr_q.delete();
        exp_start = -1;
        exp_cmp   = -1;
        exp_rej   = -1;
        beat_cyc  = -1;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
    endtask

    task automatic run(int n, logic [31:0] base, int gp, int lmin, int lmax, int dd,
                       bit nz, bit rj, int rst_after);
        int guard = 0;
        n_m = n; base_m = base; gnt_pct = gp; lat_min = lmin; lat_max = lmax;
        done_dly = dd; noise = nz; rej_exec = rj;
        start_pending = 1'b1;
        while ((op || start_pending) && guard < 3000) begin
            if (rst_after > 0 && op && rcv == rst_after) begin
                do_reset();
                break;
            end
            tick();
            guard++;
        end
        check("run_finished", 32'(op || start_pending), 32'd0);
        op = 1'b0;
        start_pending = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_word      = '0;
        cfg_base_addr = '0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        arr_done      = 1'b0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; done_dly = 1; noise = 1'b0; rej_exec = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        run(3, 32'h0000_1000, 100, 2, 2, 5, 1'b0, 1'b0, 0);
        run(0, 32'h0000_2000, 100, 1, 1, 3, 1'b0, 1'b0, 0);
        run(8, 32'h0000_4000, 40, 10, 10, 2, 1'b0, 1'b0, 0);
        run(4, 32'h0000_3000, 70, 1, 4, 6, 1'b0, 1'b1, 0);
        run(5, 32'h0000_5000, 100, 3, 3, 2, 1'b0, 1'b0, 2);
        run(5, 32'h0000_5000, 100, 1, 3, 2, 1'b0, 1'b0, 0);
        run(2, 32'hFFFF_FFFC, 100, 1, 2, 1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 60; i++) begin
            int          n, lmin;
            logic [31:0] base;
            n    = ($urandom_range(7) == 0) ? 0 : $urandom_range(20, 1);
            base = ($urandom_range(5) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            lmin = $urandom_range(3, 1);
            run(n, base, $urandom_range(100, 20), lmin, $urandom_range(12, lmin),
                $urandom_range(8, 1), 1'b1, 1'(($urandom_range(1))),
                ($urandom_range(9) == 0 && n > 2) ? $urandom_range(n - 1, 1) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
